// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

    // Frame tracker states: between frames, or partway through one.
    typedef enum logic {
        FRM_IDLE = 1'b0,
        FRM_IN   = 1'b1
    } frm_state_t;

    // Ceiling log2 for sizing pointers and counters from parameters.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Small circular register buffer that absorbs FIFO read data so the stream
// side can stall without losing words already requested from the FIFO.
module fifo_rd_obuf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Storage and pointers; the caller never pushes into a full buffer
    // without popping in the same cycle, nor pops an empty one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (i_pop) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({i_push, i_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head comes straight from a register, so it only moves on a pop.
    assign o_head  = mem[rd_ptr];
    assign o_empty = (count == '0);
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_count = count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the dual-clock FIFO: turns rd_en/empty/data into a
// valid/ready stream at one beat per cycle and measures frame lengths.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_fifo_rd_en,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH:0]   i_fifo_rd_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_last,
    output logic [LEN_WIDTH-1:0]  o_frame_len,
    output logic                  o_frame_len_valid,
    output logic                  o_len_ovf
);

    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int CNT_W     = clog2(BUF_DEPTH) + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    logic                  run_q;
    logic [RD_LATENCY-1:0] infl;
    logic [CNT_W-1:0]      in_flight_cnt;
    logic [CNT_W-1:0]      buf_count;
    logic [CNT_W:0]        committed;
    logic                  buf_full;
    logic                  buf_empty;
    logic [DATA_WIDTH:0]   head;
    logic                  push;
    logic                  pop;

    frm_state_t           state, state_nxt;
    logic [LEN_WIDTH-1:0] cnt, cnt_nxt, bumped;
    logic                 ovf_seen, ovf_seen_nxt;
    logic                 rpt, ovf_hit;
    logic [LEN_WIDTH-1:0] rpt_len;

    // Holds reads off while reset is asserted and releases them one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    // Count reads issued but not yet returned.
    always_comb begin
        in_flight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            in_flight_cnt = in_flight_cnt + CNT_W'(infl[i]);
    end

    assign pop  = o_m_valid && i_m_ready;
    assign push = infl[RD_LATENCY-1];

    // Issue a read only if its word is guaranteed a slot on return; a pop this
    // cycle frees one. The full guard is redundant with the slot sum but keeps
    // the buffer safe if the sum logic is ever altered.
    always_comb begin
        committed    = {1'b0, buf_count} + {1'b0, in_flight_cnt} - (CNT_W + 1)'(pop);
        o_fifo_rd_en = run_q && !i_fifo_empty
                       && (committed < (CNT_W + 1)'(BUF_DEPTH))
                       && !(buf_full && !pop);
    end

    // Shift register of issued reads; the bit leaving the top marks valid data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) infl <= '0;
        else          infl <= (infl << 1) | RD_LATENCY'(o_fifo_rd_en);
    end

    fifo_rd_obuf #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_obuf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data (i_fifo_rd_data),
        .i_pop       (pop),
        .o_head      (head),
        .o_full      (buf_full),
        .o_empty     (buf_empty),
        .o_count     (buf_count)
    );

    assign o_m_valid = !buf_empty;
    assign o_m_data  = head[DATA_WIDTH-1:0];
    assign o_m_last  = head[DATA_WIDTH];

    // Frame tracker state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= FRM_IDLE;
            cnt      <= '0;
            ovf_seen <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ovf_seen <= ovf_seen_nxt;
        end
    end

    // Frame tracker next state: advances only on a pop; length saturates and
    // flags overflow once per frame.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ovf_seen_nxt = ovf_seen;
        bumped       = cnt;
        rpt          = 1'b0;
        rpt_len      = cnt;
        ovf_hit      = 1'b0;
        if (pop) begin
            unique case (state)
                FRM_IDLE: begin
                    if (o_m_last) begin
                        rpt     = 1'b1;
                        rpt_len = LEN_WIDTH'(1);
                    end else begin
                        state_nxt    = FRM_IN;
                        cnt_nxt      = LEN_WIDTH'(1);
                        ovf_seen_nxt = 1'b0;
                    end
                end
                FRM_IN: begin
                    if (cnt == LEN_MAX) begin
                        bumped       = LEN_MAX;
                        ovf_hit      = !ovf_seen;
                        ovf_seen_nxt = 1'b1;
                    end else begin
                        bumped = cnt + LEN_WIDTH'(1);
                    end
                    cnt_nxt = bumped;
                    if (o_m_last) begin
                        rpt          = 1'b1;
                        rpt_len      = bumped;
                        state_nxt    = FRM_IDLE;
                        ovf_seen_nxt = 1'b0;
                    end
                end
                default: state_nxt = FRM_IDLE;
            endcase
        end
    end

    // Registered report outputs: pulses land the cycle after the deciding pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_len       <= '0;
            o_frame_len_valid <= 1'b0;
            o_len_ovf         <= 1'b0;
        end else begin
            o_frame_len_valid <= rpt;
            o_len_ovf         <= ovf_hit;
            if (rpt) o_frame_len <= rpt_len;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (read latency 1 and 3, 4-bit
// length counter) fed by behavioural non-FWFT FIFO models with identical data.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    logic rst_n;
    logic m_ready;

    logic [1:0]       f_empty, rd_en, m_valid, m_last, fl_valid, ovf;
    logic [1:0][32:0] f_data;
    logic [1:0][31:0] m_data;
    logic [1:0][3:0]  fl_len;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(1), .LEN_WIDTH(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .o_fifo_rd_en(rd_en[0]), .i_fifo_empty(f_empty[0]),
        .i_fifo_rd_data(f_data[0]), .o_m_valid(m_valid[0]), .i_m_ready(m_ready),
        .o_m_data(m_data[0]), .o_m_last(m_last[0]), .o_frame_len(fl_len[0]),
        .o_frame_len_valid(fl_valid[0]), .o_len_ovf(ovf[0]));

    fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(3), .LEN_WIDTH(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .o_fifo_rd_en(rd_en[1]), .i_fifo_empty(f_empty[1]),
        .i_fifo_rd_data(f_data[1]), .o_m_valid(m_valid[1]), .i_m_ready(m_ready),
        .o_m_data(m_data[1]), .o_m_last(m_last[1]), .o_frame_len(fl_len[1]),
        .o_frame_len_valid(fl_valid[1]), .o_len_ovf(ovf[1]));

    // ---------------- FIFO models ----------------
    logic [32:0] mem [2][1024];
    int unsigned wr [2] = '{0, 0};
    int unsigned rd [2] = '{0, 0};
    logic [32:0] pipe [2][3];
    logic [32:0] sent [1024];
    int          sent_n = 0;

    assign f_empty[0] = (rd[0] == wr[0]);
    assign f_empty[1] = (rd[1] == wr[1]);
    assign f_data[0]  = pipe[0][0];
    assign f_data[1]  = pipe[1][2];

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            pipe[l][2] <= pipe[l][1];
            pipe[l][1] <= pipe[l][0];
            if (rd_en[l]) begin
                pipe[l][0] <= mem[l][rd[l][9:0]];
                rd[l]      <= rd[l] + 1;
            end
        end
    end

    // ---------------- Monitor (records only) ----------------
    logic [32:0] rx [2][1024];
    int rx_cyc [2][1024];
    int rx_n [2] = '{0, 0};
    logic [3:0] fl_log [2][64];
    int fl_n [2] = '{0, 0};
    int ovf_log [2][16];
    int ovf_n [2] = '{0, 0};
    int stall_err [2] = '{0, 0};
    int occ_err [2] = '{0, 0};
    int uf_err [2] = '{0, 0};
    int drop_err [2] = '{0, 0};
    logic prv_stall [2] = '{1'b0, 1'b0};
    logic [32:0] prv_word [2];
    logic strm_chk = 1'b0;
    int cyc = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (int'(dut0.buf_count) + int'(dut0.in_flight_cnt) > 2) occ_err[0]++;
        if (int'(dut1.buf_count) + int'(dut1.in_flight_cnt) > 4) occ_err[1]++;
        for (int l = 0; l < 2; l++) begin
            if (ovf[l]) begin
                if (ovf_n[l] < 16) ovf_log[l][ovf_n[l]] = rx_n[l];
                ovf_n[l]++;
            end
            if (fl_valid[l]) begin
                if (fl_n[l] < 64) fl_log[l][fl_n[l]] = fl_len[l];
                fl_n[l]++;
            end
            if (rst_n && prv_stall[l] && (!m_valid[l] || {m_last[l], m_data[l]} != prv_word[l]))
                stall_err[l]++;
            prv_stall[l] = rst_n && m_valid[l] && !m_ready;
            prv_word[l]  = {m_last[l], m_data[l]};
            if (rd_en[l] && f_empty[l]) uf_err[l]++;
            if (strm_chk && !f_empty[l] && !rd_en[l]) drop_err[l]++;
            if (m_valid[l] && m_ready && rst_n) begin
                if (rx_n[l] < 1024) begin
                    rx[l][rx_n[l]]     = {m_last[l], m_data[l]};
                    rx_cyc[l][rx_n[l]] = cyc;
                end
                rx_n[l]++;
            end
        end
    end

    // ---------------- Checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        for (int l = 0; l < 2; l++) begin
            mem[l][wr[l][9:0]] = {last, d};
            wr[l]++;
        end
        sent[sent_n] = {last, d};
        sent_n++;
    endtask

    task automatic wait_rx(input int t0, input int t1, input int maxc, input string nm);
        int c;
        c = 0;
        while ((rx_n[0] < t0 || rx_n[1] < t1) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk({nm, " beats arrived"}, 64'(c < maxc), 64'(1));
    endtask

    task automatic chk_rx(input int l, input int rbase, input int sbase, input int n, input string nm);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s L%0d beat%0d", nm, l, i), 64'(rx[l][rbase + i]), 64'(sent[sbase + i]));
    endtask

    // Frame table: beats per frame, expected reported length, expected ovf pulses.
    typedef struct {
        int       beats;
        logic [3:0] len;
        int       ovf;
    } frm_vec_t;

    frm_vec_t tbl [6];

    // ---------------- Stimulus ----------------
    initial begin
        int fr [2];
        int fv [2];
        int rb [2];
        int fb [2];
        int ob [2];
        int sb, c, pos, novf;

        tbl[0] = '{beats: 1,  len: 4'd1,  ovf: 0};
        tbl[1] = '{beats: 2,  len: 4'd2,  ovf: 0};
        tbl[2] = '{beats: 7,  len: 4'd7,  ovf: 0};
        tbl[3] = '{beats: 15, len: 4'd15, ovf: 0};
        tbl[4] = '{beats: 16, len: 4'd15, ovf: 1};
        tbl[5] = '{beats: 20, len: 4'd15, ovf: 1};

        // Reset held with the FIFO non-empty.
        rst_n   = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h100 + i, i == 2);
        repeat (4) @(negedge clk);
        chk("reset ctrl outputs", 64'({rd_en, m_valid, m_last, fl_valid, ovf}), 64'(0));
        chk("reset data", {m_data[1], m_data[0]}, 64'(0));
        chk("reset frame len", 64'({fl_len[1], fl_len[0]}), 64'(0));

        // Release and measure rd_en -> valid latency.
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        fr = '{-1, -1};
        fv = '{-1, -1};
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (fr[l] < 0 && rd_en[l])   fr[l] = k;
                if (fv[l] < 0 && m_valid[l]) fv[l] = k;
            end
        end
        chk("first rd_en seen L0", 64'(fr[0] >= 0), 64'(1));
        chk("latency L0", 64'(fv[0] - fr[0]), 64'(2));
        chk("latency L1", 64'(fv[1] - fr[1]), 64'(4));
        wait_rx(3, 3, 50, "startup");
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk_rx(l, 0, 0, 3, "startup");
            chk($sformatf("startup len L%0d", l), 64'(fl_log[l][0]), 64'(3));
        end

        // Streaming: 64 words with ready held high.
        tick();
        rb = rx_n; fb = fl_n; sb = sent_n;
        strm_chk = 1'b1;
        for (int i = 0; i < 64; i++) push(32'h2000 + i, (i % 8) == 7);
        wait_rx(rb[0] + 64, rb[1] + 64, 300, "stream");
        strm_chk = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk_rx(l, rb[l], sb, 64, "stream");
            chk($sformatf("stream count L%0d", l), 64'(rx_n[l] - rb[l]), 64'(64));
            chk($sformatf("stream back-to-back L%0d", l), 64'(rx_cyc[l][rb[l] + 63] - rx_cyc[l][rb[l]]), 64'(63));
            chk($sformatf("stream rd_en drops L%0d", l), 64'(drop_err[l]), 64'(0));
            chk($sformatf("stream reports L%0d", l), 64'(fl_n[l] - fb[l]), 64'(8));
            for (int f = 0; f < 8; f++)
                chk($sformatf("stream len L%0d f%0d", l, f), 64'(fl_log[l][fb[l] + f]), 64'(8));
        end

        // Frame table back-to-back, including saturation boundaries.
        tick();
        rb = rx_n; fb = fl_n; ob = ovf_n; sb = sent_n;
        c = 0;
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < tbl[i].beats; b++) push(32'h3000 + i * 256 + b, b == tbl[i].beats - 1);
            c += tbl[i].beats;
        end
        wait_rx(rb[0] + c, rb[1] + c, 400, "frames");
        repeat (4) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk_rx(l, rb[l], sb, c, "frames");
            chk($sformatf("frame reports L%0d", l), 64'(fl_n[l] - fb[l]), 64'(6));
            pos  = rb[l];
            novf = 0;
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("frame len L%0d f%0d", l, i), 64'(fl_log[l][fb[l] + i]), 64'(tbl[i].len));
                if (tbl[i].ovf != 0) begin
                    chk($sformatf("ovf position L%0d f%0d", l, i), 64'(ovf_log[l][ob[l] + novf]), 64'(pos + 16));
                    novf++;
                end
                pos += tbl[i].beats;
            end
            chk($sformatf("ovf pulses L%0d", l), 64'(ovf_n[l] - ob[l]), 64'(novf));
        end

        // Random backpressure.
        tick();
        rb = rx_n; sb = sent_n;
        for (int i = 0; i < 100; i++) push(32'h4000 + i, (i % 10) == 9);
        c = 0;
        while ((rx_n[0] < rb[0] + 100 || rx_n[1] < rb[1] + 100) && c < 3000) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
            c++;
        end
        chk("backpressure beats arrived", 64'(c < 3000), 64'(1));
        tick();
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk_rx(l, rb[l], sb, 100, "bp");
            chk($sformatf("bp count L%0d", l), 64'(rx_n[l] - rb[l]), 64'(100));
        end

        // Reset mid-frame with the buffers full.
        tick();
        m_ready = 1'b0;
        sb = sent_n;
        push(32'h5000, 1'b0);
        c = 0;
        while (!(m_valid[0] && m_valid[1]) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("rst-mid first beat valid", 64'(c < 50), 64'(1));
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(32'h5000 + i, i == 6);
        repeat (12) @(negedge clk);
        chk("rst-mid valid before reset", 64'(m_valid), 64'(2'b11));
        chk("rst-mid buffered L0", 64'(dut0.buf_count), 64'(2));
        chk("rst-mid buffered L1", 64'(dut1.buf_count), 64'(4));
        rb = rx_n; fb = fl_n;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst-mid drained", 64'({m_valid, rd_en}), 64'(0));
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        wait_rx(rb[0] + 4, rb[1] + 2, 50, "rst-mid");
        repeat (5) @(negedge clk);
        chk_rx(0, rb[0], sb + 3, 4, "rst-mid");
        chk_rx(1, rb[1], sb + 5, 2, "rst-mid");
        chk("rst-mid count L0", 64'(rx_n[0] - rb[0]), 64'(4));
        chk("rst-mid count L1", 64'(rx_n[1] - rb[1]), 64'(2));
        chk("rst-mid len L0", 64'(fl_log[0][fb[0]]), 64'(4));
        chk("rst-mid len L1", 64'(fl_log[1][fb[1]]), 64'(2));

        // Whole-run invariants.
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("stall stability L%0d", l), 64'(stall_err[l]), 64'(0));
            chk($sformatf("occupancy bound L%0d", l), 64'(occ_err[l]), 64'(0));
            chk($sformatf("read while empty L%0d", l), 64'(uf_err[l]), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
